// File: rtl/fetch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_if
// Brief    : PC, instruction-memory and decoded-output bundle for fetch_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_seq_if;
    logic [63:0] PC_new;
    logic        pc_valid;
    logic        pc_ready;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_ack;
    logic        imem_err;

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        out_valid;
    logic        instr_invalid;
    logic        mem_error;
    logic        out_ready;

    modport slave (
        input  PC_new, pc_valid, imem_rdata, imem_ack, imem_err, out_ready,
        output pc_ready, imem_req, imem_addr, icode, ifun, rA, rB, valC, valP,
               out_valid, instr_invalid, mem_error
    );

    modport master (
        output PC_new, pc_valid, imem_rdata, imem_ack, imem_err, out_ready,
        input  pc_ready, imem_req, imem_addr, icode, ifun, rA, rB, valC, valP,
               out_valid, instr_invalid, mem_error
    );
endinterface

`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Brief    : Byte-serial Y86-64 instruction fetch and field decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
    parameter int WAIT_LIMIT = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    fetch_seq_if.slave bus
);
    localparam int c_WAIT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [63:0]         r_pc;
    logic [3:0]          r_cnt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [3:0]          r_icode;
    logic [3:0]          r_ifun;
    logic [3:0]          r_ra;
    logic [3:0]          r_rb;
    logic [63:0]         r_valc;
    logic [63:0]         r_valp;
    logic                r_inv;
    logic                r_merr;

    logic [3:0]          w_op;
    logic [3:0]          w_len;
    logic                w_bad;
    logic                w_last;
    logic                w_timeout;
    logic                w_hasreg;
    logic                w_cgrab;
    logic [2:0]          w_cidx;

    // Byte 0 decodes the length straight from the incoming data.
    assign w_op = (r_cnt == 4'd0) ? bus.imem_rdata[7:4] : r_icode;

    always_comb begin
        case (w_op)
            4'h0, 4'h1, 4'h9:       w_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
            4'h7, 4'h8:             w_len = 4'd9;
            4'h3, 4'h4, 4'h5:       w_len = 4'd10;
            default:                w_len = 4'd0;
        endcase
    end

    assign w_bad     = (w_len == 4'd0);
    assign w_last    = (r_cnt == w_len - 4'd1);
    assign w_timeout = !bus.imem_ack && (r_wait == c_WAIT_W'(WAIT_LIMIT - 1));
    assign w_hasreg  = (r_cnt == 4'd1) && ((w_len == 4'd2) || (w_len == 4'd10));

    always_comb begin
        w_cgrab = 1'b0;
        w_cidx  = 3'd0;
        if (r_icode == 4'h3 || r_icode == 4'h4 || r_icode == 4'h5) begin
            w_cgrab = (r_cnt >= 4'd2);
            w_cidx  = 3'(r_cnt - 4'd2);
        end else if (r_icode == 4'h7 || r_icode == 4'h8) begin
            w_cgrab = (r_cnt >= 4'd1);
            w_cidx  = 3'(r_cnt - 4'd1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.pc_valid) w_next = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.imem_err || w_bad || w_last) w_next = DONE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= 64'd0;
            r_cnt   <= 4'd0;
            r_wait  <= '0;
            r_icode <= 4'h0;
            r_ifun  <= 4'h0;
            r_ra    <= 4'hF;
            r_rb    <= 4'hF;
            r_valc  <= 64'd0;
            r_valp  <= 64'd0;
            r_inv   <= 1'b0;
            r_merr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.pc_valid) begin
                        r_pc    <= bus.PC_new;
                        r_cnt   <= 4'd0;
                        r_wait  <= '0;
                        r_icode <= 4'h0;
                        r_ifun  <= 4'h0;
                        r_ra    <= 4'hF;
                        r_rb    <= 4'hF;
                        r_valc  <= 64'd0;
                        r_valp  <= 64'd0;
                        r_inv   <= 1'b0;
                        r_merr  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        r_wait <= '0;
                        if (bus.imem_err) begin
                            // Faulting byte is not captured; fields stay as fetched so far.
                            r_merr <= 1'b1;
                            r_valp <= r_pc;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            if (r_cnt == 4'd0) begin
                                r_icode <= bus.imem_rdata[7:4];
                                r_ifun  <= bus.imem_rdata[3:0];
                            end
                            if (w_hasreg) begin
                                r_ra <= bus.imem_rdata[7:4];
                                r_rb <= bus.imem_rdata[3:0];
                            end
                            if (w_cgrab) r_valc[{w_cidx, 3'b000} +: 8] <= bus.imem_rdata;
                            if (w_bad) begin
                                r_inv  <= 1'b1;
                                r_valp <= r_pc + 64'd1;
                            end else if (w_last) begin
                                r_valp <= r_pc + 64'(w_len);
                            end
                        end
                    end else if (w_timeout) begin
                        r_merr <= 1'b1;
                        r_valp <= r_pc;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_ready      = (r_state == IDLE);
    assign bus.imem_req      = (r_state == FETCH);
    assign bus.out_valid     = (r_state == DONE);
    assign bus.imem_addr     = (r_state == FETCH) ? (r_pc + {60'd0, r_cnt}) : 64'd0;
    assign bus.icode         = r_icode;
    assign bus.ifun          = r_ifun;
    assign bus.rA            = r_ra;
    assign bus.rB            = r_rb;
    assign bus.valC          = r_valc;
    assign bus.valP          = r_valp;
    assign bus.instr_invalid = r_inv;
    assign bus.mem_error     = r_merr;
endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Brief    : Self-checking bench for fetch_seq with a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;
    localparam int c_WL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_seq_if ifc ();

    fetch_seq #(.WAIT_LIMIT(c_WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        inv;
        logic        merr;
    } res_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  prog [16];
    logic [63:0] base;
    int          wt = 0;
    int          err_idx = 99;
    int          hold_idx = 99;
    int          stall = 0;
    bit          late_ack = 1'b0;
    logic [63:0] mem_idx;
    logic [63:0] addr_q [$];

    // Memory: wt stall cycles before every ack, optional error / withheld byte.
    always @(negedge clk) begin
        ifc.imem_ack = 1'b0;
        ifc.imem_err = 1'b0;
        if (late_ack) begin
            ifc.imem_ack   = 1'b1;
            ifc.imem_rdata = 8'hAA;
        end else if (ifc.imem_req) begin
            mem_idx = ifc.imem_addr - base;
            if (mem_idx == 64'(hold_idx)) begin
                stall = 0;
            end else if (stall < wt) begin
                stall++;
            end else begin
                stall          = 0;
                ifc.imem_ack   = 1'b1;
                ifc.imem_rdata = prog[mem_idx[3:0]];
                ifc.imem_err   = (mem_idx == 64'(err_idx));
                addr_q.push_back(ifc.imem_addr);
            end
        end else begin
            stall = 0;
        end
    end

    function automatic int len_of(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    // Expected result of fetching prog at pc when byte 'fault' errors or never arrives.
    function automatic res_t model(input logic [63:0] pc, input int fault);
        res_t e;
        int   len, nb, off;
        e    = '0;
        e.ra = 4'hF;
        e.rb = 4'hF;
        len  = len_of(prog[0][7:4]);
        if (fault == 0) begin
            e.merr = 1'b1;
            e.valp = pc;
            return e;
        end
        e.icode = prog[0][7:4];
        e.ifun  = prog[0][3:0];
        if (len == 0) begin
            e.inv  = 1'b1;
            e.valp = pc + 64'd1;
            return e;
        end
        nb = (fault < len) ? fault : len;
        if ((len == 2 || len == 10) && nb > 1) begin
            e.ra = prog[1][7:4];
            e.rb = prog[1][3:0];
        end
        off = (len == 10) ? 2 : (len == 9) ? 1 : 0;
        if (off != 0)
            for (int k = 0; k < 8; k++)
                if (off + k < nb) e.valc |= 64'(prog[off + k]) << (8 * k);
        if (nb < len) begin
            e.merr = 1'b1;
            e.valp = pc;
        end else begin
            e.valp = pc + 64'(len);
        end
        return e;
    endfunction

    function automatic int exp_lat();
        int n;
        n = (len_of(prog[0][7:4]) == 0) ? 1 : len_of(prog[0][7:4]);
        if (err_idx < n)  return 1 + (err_idx + 1) * (wt + 1);
        if (hold_idx < n) return 1 + hold_idx * (wt + 1) + c_WL;
        return 1 + n * (wt + 1);
    endfunction

    function automatic int exp_acks();
        int n;
        n = (len_of(prog[0][7:4]) == 0) ? 1 : len_of(prog[0][7:4]);
        if (err_idx < n)  return err_idx + 1;
        if (hold_idx < n) return hold_idx;
        return n;
    endfunction

    function automatic bit addr_ok(input logic [63:0] pc, input int n);
        if (addr_q.size() != n) return 1'b0;
        for (int k = 0; k < n; k++)
            if (addr_q[k] !== pc + 64'(k)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic res_t observed();
        return {ifc.icode, ifc.ifun, ifc.rA, ifc.rB, ifc.valC, ifc.valP,
                ifc.instr_invalid, ifc.mem_error};
    endfunction

    // Offer pc, then count cycles from the accept cycle until out_valid shows.
    task automatic run_fetch(input logic [63:0] pc, output res_t r, output int lat);
        int k;
        base = pc;
        addr_q.delete();
        k = 0;
        @(negedge clk);
        while (!ifc.pc_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        ifc.PC_new   = pc;
        ifc.pc_valid = 1'b1;
        @(negedge clk);
        ifc.pc_valid = 1'b0;
        ifc.PC_new   = {$urandom, $urandom};
        lat = 1;
        while (!ifc.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        r = observed();
    endtask

    task automatic test_reset();
        res_t rst_exp;
        rst_exp = res_t'{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ifc.out_valid, ifc.imem_req, ifc.pc_ready, ifc.instr_invalid, ifc.mem_error} !== 5'b00100) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00100",
                     {ifc.out_valid, ifc.imem_req, ifc.pc_ready, ifc.instr_invalid, ifc.mem_error});
        end
        n_vec++;
        if (observed() !== rst_exp) begin
            n_err++;
            $display("FAIL reset_fields: got %h expected %h", observed(), rst_exp);
        end
        n_vec++;
        if (ifc.imem_addr !== 64'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h expected 0", ifc.imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nop();
        res_t r, e;
        int   lat;
        prog[0] = 8'h10; wt = 0; err_idx = 99; hold_idx = 99;
        run_fetch(64'h100, r, lat);
        e = res_t'{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 1'b0, 1'b0};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL nop_fields: got %h expected %h", r, e); end
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL nop_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_irmovq();
        res_t r, e;
        int   lat;
        logic [7:0] b [10] = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 10; k++) prog[k] = b[k];
        wt = 0; err_idx = 99; hold_idx = 99;
        run_fetch(64'h0, r, lat);
        e = res_t'{4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'hA, 1'b0, 1'b0};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL irmovq_fields: got %h expected %h", r, e); end
        n_vec++;
        if (lat !== 11) begin n_err++; $display("FAIL irmovq_latency: got %0d expected 11", lat); end
    endtask

    task automatic test_jxx_wait();
        res_t r, e;
        int   lat;
        logic [7:0] b [9] = '{8'h73, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 9; k++) prog[k] = b[k];
        wt = 2; err_idx = 99; hold_idx = 99;
        run_fetch(64'h40, r, lat);
        e = res_t'{4'h7, 4'h3, 4'hF, 4'hF, 64'h1000, 64'h49, 1'b0, 1'b0};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL jxx_fields: got %h expected %h", r, e); end
        n_vec++;
        if (lat !== 28) begin n_err++; $display("FAIL jxx_latency: got %0d expected 28", lat); end
        n_vec++;
        if (addr_ok(64'h40, 9) !== 1'b1) begin
            n_err++;
            $display("FAIL jxx_addr: got %0d addresses expected 9 stepping from 40", addr_q.size());
        end
    endtask

    task automatic test_errors();
        res_t r, e;
        int   lat;
        logic [7:0] b [10] = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        prog[0] = 8'hD0; wt = 0; err_idx = 99; hold_idx = 99;
        run_fetch(64'h200, r, lat);
        e = res_t'{4'hD, 4'h0, 4'hF, 4'hF, 64'h0, 64'h201, 1'b1, 1'b0};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL invalid_fields: got %h expected %h", r, e); end
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL invalid_latency: got %0d expected 2", lat); end

        for (int k = 0; k < 10; k++) prog[k] = b[k];
        hold_idx = 0;
        run_fetch(64'h500, r, lat);
        e = res_t'{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h500, 1'b0, 1'b1};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL timeout_fields: got %h expected %h", r, e); end
        n_vec++;
        if (lat !== 1 + c_WL) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 1 + c_WL); end

        hold_idx = 99; err_idx = 3;
        run_fetch(64'h600, r, lat);
        e = res_t'{4'h3, 4'h0, 4'hF, 4'h3, 64'h08, 64'h600, 1'b0, 1'b1};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL memerr_fields: got %h expected %h", r, e); end
        n_vec++;
        if (lat !== 5) begin n_err++; $display("FAIL memerr_latency: got %0d expected 5", lat); end
        err_idx = 99;
    endtask

    task automatic test_reset_mid();
        int   k;
        res_t rst_exp;
        logic [7:0] b [10] = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rst_exp = res_t'{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) prog[i] = b[i];
        wt = 2; err_idx = 99; hold_idx = 99;
        base = 64'h700;
        addr_q.delete();
        k = 0;
        @(negedge clk);
        while (!ifc.pc_ready && k < 100) begin @(negedge clk); k++; end
        ifc.PC_new   = 64'h700;
        ifc.pc_valid = 1'b1;
        @(negedge clk);
        ifc.pc_valid = 1'b0;
        k = 0;
        while (addr_q.size() < 5 && k < 200) begin @(negedge clk); k++; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ifc.out_valid, ifc.imem_req, ifc.pc_ready, ifc.imem_addr} !== {3'b001, 64'h0}) begin
            n_err++;
            $display("FAIL midreset_immediate: got ov=%b req=%b rdy=%b addr=%h expected 0 0 1 0",
                     ifc.out_valid, ifc.imem_req, ifc.pc_ready, ifc.imem_addr);
        end
        late_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ifc.out_valid, ifc.imem_req, ifc.pc_ready} !== 3'b001 || observed() !== rst_exp) begin
            n_err++;
            $display("FAIL late_ack: got ov=%b req=%b rdy=%b fields=%h expected 0 0 1 %h",
                     ifc.out_valid, ifc.imem_req, ifc.pc_ready, observed(), rst_exp);
        end
        late_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        res_t r, e;
        int   lat;
        prog[0] = 8'h60; prog[1] = 8'h12; wt = 0; err_idx = 99; hold_idx = 99;
        ifc.out_ready = 1'b0;
        run_fetch(64'h300, r, lat);
        e = res_t'{4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h302, 1'b0, 1'b0};
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL bp_fields: got %h expected %h", r, e); end
        ifc.PC_new   = 64'hDEAD;
        ifc.pc_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (observed() !== e || ifc.out_valid !== 1'b1 || ifc.pc_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: got %h ov=%b rdy=%b expected %h ov=1 rdy=0",
                         observed(), ifc.out_valid, ifc.pc_ready, e);
            end
        end
        ifc.pc_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        #1;
        n_vec++;
        if (ifc.pc_ready !== 1'b0) begin n_err++; $display("FAIL bp_handshake_rdy: got %b expected 0", ifc.pc_ready); end
        @(negedge clk);
        n_vec++;
        if ({ifc.out_valid, ifc.pc_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got ov=%b rdy=%b expected 0 1", ifc.out_valid, ifc.pc_ready);
        end
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 60; i++) begin
            res_t        r, e;
            int          lat, len, u;
            logic [63:0] pc;
            for (int k = 0; k < 16; k++) prog[k] = 8'($urandom);
            prog[0][7:4] = 4'($urandom_range(0, 13));
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 9));
            wt = $urandom_range(0, 2);
            err_idx = 99; hold_idx = 99;
            len = len_of(prog[0][7:4]);
            u = $urandom_range(0, 9);
            if (u == 0)      err_idx  = $urandom_range(0, (len == 0) ? 0 : len - 1);
            else if (u == 1) hold_idx = $urandom_range(0, (len == 0) ? 0 : len - 1);
            run_fetch(pc, r, lat);
            e = model(pc, (err_idx < hold_idx) ? err_idx : hold_idx);
            n_vec++;
            if (r !== e) begin n_err++; $display("FAIL rand%0d_fields: got %h expected %h", i, r, e); end
            n_vec++;
            if (lat !== exp_lat()) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat()); end
            n_vec++;
            if (addr_ok(pc, exp_acks()) !== 1'b1) begin
                n_err++;
                $display("FAIL rand%0d_addr: got %0d addresses expected %0d from %h", i, addr_q.size(), exp_acks(), pc);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.PC_new    = 64'h0;
        ifc.pc_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) prog[k] = 8'h00;
        base = 64'h0;
        test_reset();
        test_nop();
        test_irmovq();
        test_jxx_wait();
        test_errors();
        test_reset_mid();
        test_backpressure();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16, meaning the maximum cycles to wait for imem_ack on one byte before a timeout error.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PC_new, input, 64, address of the next instruction, as produced by PC update.
REQ-005 SHALL have port pc_valid, input, 1, meaning PC_new is valid.
REQ-006 SHALL have port pc_ready, output, 1, meaning a PC is accepted this cycle.
REQ-007 SHALL have port imem_req, output, 1, byte read request.
REQ-008 SHALL have port imem_addr, output, 64, byte address of the current request.
REQ-009 SHALL have port imem_rdata, input, 8, read byte, valid with imem_ack.
REQ-010 SHALL have port imem_ack, input, 1, read completion.
REQ-011 SHALL have port imem_err, input, 1, read fault, sampled only with imem_ack.
REQ-012 SHALL have outputs icode and ifun (4 each), rA and rB (4 each), valC (64) and valP (64): the decoded instruction fields.
REQ-013 SHALL have outputs out_valid (1), instr_invalid (1) and mem_error (1), plus input out_ready (1).

Function
REQ-014 SHALL implement the states IDLE, FETCH and DONE.
REQ-015 IDLE: pc_ready=1; on pc_valid, SHALL latch PC_new into pc_reg, clear the byte count cnt=0 and all field registers, and go to FETCH.
REQ-016 FETCH: imem_req=1 and imem_addr=pc_reg+cnt (mod 2^64); each cycle with imem_ack captures imem_rdata as byte[cnt] and increments cnt.
REQ-017 Byte 0 SHALL set icode=rdata[7:4] and ifun=rdata[3:0], and fix the instruction length len.
REQ-018 Length by icode: 0, 1, 9 = 1; 2, 6, A, B = 2; 7, 8 = 9; 3, 4, 5 = 10; C-F = invalid.
REQ-019 For lengths 2 and 10, byte 1 SHALL set rA=rdata[7:4] and rB=rdata[3:0]; otherwise rA=rB=4'hF.
REQ-020 valC SHALL be assembled little-endian: bytes 2-9 for icode 3/4/5, bytes 1-8 for icode 7/8, and 0 otherwise.
REQ-021 When the byte with cnt=len-1 is acked, SHALL go to DONE with valP=pc_reg+len (64-bit wrap).
REQ-022 An invalid icode SHALL go to DONE after byte 0, with instr_invalid=1, valP=pc_reg+1 and valC=0.
REQ-023 imem_ack with imem_err=1 SHALL go to DONE with mem_error=1 and valP=pc_reg, keeping the fields captured so far.
REQ-024 A wait counter SHALL count FETCH cycles without ack and clear on each ack.
REQ-025 On reaching WAIT_LIMIT with no ack, SHALL take the REQ-023 path with mem_error=1.
REQ-026 DONE: out_valid=1 and all outputs held stable; imem_req=0.
REQ-027 In DONE, out_valid&&out_ready SHALL return to IDLE on the next cycle, so a new PC is accepted no earlier than the cycle after the handshake.
REQ-028 pc_valid outside IDLE SHALL be ignored (pc_ready=0).
REQ-029 imem_ack outside FETCH SHALL be ignored.
REQ-030 Latency with zero-wait memory SHALL be: pc accept at cycle N, out_valid at N+1+len.
REQ-031 An address wrap past 2^64-1 during fetch SHALL wrap silently.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, including mid-fetch; any pending request is abandoned and a late ack is ignored.
REQ-033 Under reset: out_valid=0, imem_req=0, pc_ready=1, cnt=0, wait counter=0, instr_invalid=0, mem_error=0.
REQ-034 Under reset: icode=ifun=0, rA=rB=4'hF, valC=valP=imem_addr=0.

Verification
REQ-035 nop: PC_new=0x100, byte 0x10, immediate ack -> out_valid 2 cycles after accept; icode=1, rA=rB=F, valP=0x101.
REQ-036 irmovq: PC_new=0x0, bytes 30 F3 08 07 06 05 04 03 02 01, immediate ack -> rA=F, rB=3, valC=0x0102030405060708, valP=0xA, out_valid at cycle 11.
REQ-037 jXX and wait states: PC_new=0x40, bytes 73 then 00 10 00 00 00 00 00 00 with 2 wait cycles per byte -> ifun=3, valC=0x1000, valP=0x49; imem_addr steps 0x40..0x48.
REQ-038 Errors: byte 0xD0 -> instr_invalid=1, valP=PC+1; with WAIT_LIMIT=4 and ack withheld -> mem_error=1 after 4 FETCH cycles.
REQ-039 Reset and backpressure: rst_n low during byte 5 of rmmovq -> IDLE and out_valid=0 immediately, late ack ignored; out_ready held 0 for 3 cycles -> outputs stable, pc_ready=0.
